snail_seq_tx: RTL and testbench
===============================

SNAIL_SEQ_TX -- requirements
Module: snail_seq_tx

Interface
REQ-001 Parameter DATA_W, default 8, frame payload width in bits; legal range 2..32.
REQ-002 clk_in  input  1  clock; all state changes on rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-high.
REQ-004 data_in  input  DATA_W  frame payload, sampled at capture.
REQ-005 valid_in  input  1  payload offered this cycle.
REQ-006 ready_out  output  1  block accepts a payload this cycle.
REQ-007 sequence_out  output  1  serial bit stream toward the snail sequence detector; idle level 1.
REQ-008 busy_out  output  1  a frame is being serialized.
REQ-009 done_out  output  1  single-cycle pulse on the first idle cycle after a frame.
REQ-010 smile_cnt_out  output  8  count of 0->1 line transitions in the last frame; valid while done_out=1 and held until the next capture.

Function
REQ-011 States: IDLE, SHIFT, PARITY (present only with the macro in REQ-025); SHIFT exits to PARITY if present, else to IDLE.
REQ-012 IDLE: ready_out=1, busy_out=0, sequence_out=1.
REQ-013 Capture: valid_in=1 and ready_out=1 at a rising edge; payload latched, smile_cnt_out cleared to 0, state -> SHIFT.
REQ-014 SHIFT: DATA_W consecutive cycles; sequence_out = payload MSB first, first bit in the cycle after capture; ready_out=0, busy_out=1.
REQ-015 All outputs are registered; no combinational path from any input to any output.
REQ-016 valid_in while ready_out=0 is ignored; the payload is not queued.
REQ-017 The cycle after the last serialized bit, sequence_out=1, state=IDLE, done_out=1 for exactly one cycle.
REQ-018 A capture is permitted in the done_out cycle: back-to-back frames are separated by exactly one idle-level cycle.
REQ-019 smile_cnt_out increments once per cycle in which sequence_out is 1 and was 0 in the previous cycle. The count covers every serialized bit and the done_out cycle. The pre-frame line level is 1.
REQ-020 smile_cnt_out cannot exceed DATA_W/2+1 and does not wrap.
REQ-021 done_out is never asserted outside the cycle in REQ-017.

Reset
REQ-022 rst_in=1 forces, immediately and asynchronously: state=IDLE, sequence_out=1, ready_out=1, busy_out=0, done_out=0, smile_cnt_out=0, payload register=0.
REQ-023 Reset mid-frame aborts the frame: no done_out pulse, no partial bits after deassertion.
REQ-024 After rst_in deasserts, the first capture is accepted at the next rising edge.

Configuration
REQ-025 Macro SNAIL_TX_PARITY_EN defined: PARITY state emits one even-parity bit (XOR of the payload) after the last payload bit. Frame length is DATA_W+1 cycles. The parity bit is included in REQ-019 counting.
REQ-026 SNAIL_TX_PARITY_EN undefined: no PARITY state, no parity logic, frame length DATA_W cycles.

Structure
REQ-027 Shared package snail_pkg SHALL hold:
- state encoding typedef;
- idle line level constant (1);
- smile count width constant (8).
REQ-028 Sub-module snail_rise_counter SHALL implement the REQ-019 0->1 transition counter, with clear, enable and line inputs. All other logic stays in snail_seq_tx.

Verification
REQ-029 DATA_W=8, no parity: capture 8'hA5 -> sequence_out 1,0,1,0,0,1,0,1 on cycles 1..8 after capture. done_out=1 on cycle 9 with smile_cnt_out=3.
REQ-030 Parity enabled: capture 8'h55 -> bits 0,1,0,1,0,1,0,1, then parity 0. done_out on cycle 10 with smile_cnt_out=5.
REQ-031 No parity: 8'h00 -> smile_cnt_out=1 at done_out. 8'hFF -> smile_cnt_out=0 and sequence_out stays 1 throughout.
REQ-032 valid_in held high with 8'hA5 then 8'h3C -> second capture in the done_out cycle. Exactly one idle 1 between frames, with ready_out low during each frame. A third valid pulse during SHIFT is ignored.
REQ-033 rst_in pulsed on cycle 4 of a frame -> sequence_out=1 and ready_out=1 the same cycle, no done_out afterward, and a new capture succeeds after deassertion.
REQ-034 Loopback into the snail sequence detector: the detector's smile_out pulse count over a frame plus its done_out cycle equals smile_cnt_out.

Source files
------------

// File: rtl/snail_pkg.sv
// Shared types and constants for the snail serial transmitter.
// Build option: define SNAIL_TX_PARITY_EN to add the even-parity state.
package snail_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
`ifdef SNAIL_TX_PARITY_EN
    ST_PARITY = 2'd2,
`endif
    ST_SHIFT  = 2'd1
  } snail_state_e;

  localparam logic IDLE_LEVEL = 1'b1;
  localparam int   SMILE_W    = 8;

endpackage

// File: rtl/snail_rise_counter.sv
// Counts 0->1 transitions of the transmit line. "line" is the level the line
// takes after this edge, so the count is updated in step with the line register.
module snail_rise_counter
  import snail_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               clear,
  input  logic               enable,
  input  logic               line,
  output logic [SMILE_W-1:0] count
);

  logic prev;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      prev  <= IDLE_LEVEL;
      count <= '0;
    end else begin
      prev <= line;
      if (clear) begin
        count <= '0;
      end else if (enable && line && !prev && (count != '1)) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/snail_seq_tx.sv
// Serializes a DATA_W-bit payload MSB first onto an idle-high line.
// Build option: define SNAIL_TX_PARITY_EN to append one even-parity bit per frame.
module snail_seq_tx
  import snail_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [DATA_W-1:0]  data_in,
  input  logic               valid_in,
  output logic               ready_out,
  output logic               sequence_out,
  output logic               busy_out,
  output logic               done_out,
  output logic [SMILE_W-1:0] smile_cnt_out
);

  localparam int IDX_W = $clog2(DATA_W);

  snail_state_e      state_q, state_d;
  logic [DATA_W-1:0] payload_q, payload_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d, bit_idx_m1;
  logic              seq_d, done_d, ready_d, busy_d, capture;

  assign bit_idx_m1 = bit_idx_q - 1'b1;

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    payload_d = payload_q;
    bit_idx_d = bit_idx_q;
    seq_d     = sequence_out;
    done_d    = 1'b0;
    capture   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        seq_d = IDLE_LEVEL;
        if (valid_in && ready_out) begin
          capture   = 1'b1;
          payload_d = data_in;
          seq_d     = data_in[DATA_W-1];
          bit_idx_d = IDX_W'(DATA_W - 1);
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // bit_idx_q is the index of the bit currently on the line.
        if (bit_idx_q != '0) begin
          bit_idx_d = bit_idx_m1;
          seq_d     = payload_q[bit_idx_m1];
        end else begin
`ifdef SNAIL_TX_PARITY_EN
          state_d = ST_PARITY;
          seq_d   = ^payload_q;
`else
          state_d = ST_IDLE;
          seq_d   = IDLE_LEVEL;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef SNAIL_TX_PARITY_EN
      ST_PARITY: begin
        state_d = ST_IDLE;
        seq_d   = IDLE_LEVEL;
        done_d  = 1'b1;
      end
`endif
      default: begin
        state_d = ST_IDLE;
        seq_d   = IDLE_LEVEL;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  // NOTE: the payload is an ordinary register, not a memory array, so it
  // takes a reset value like the rest of the state.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      payload_q    <= '0;
      bit_idx_q    <= '0;
      sequence_out <= IDLE_LEVEL;
      ready_out    <= 1'b1;
      busy_out     <= 1'b0;
      done_out     <= 1'b0;
    end else begin
      state_q      <= state_d;
      payload_q    <= payload_d;
      bit_idx_q    <= bit_idx_d;
      sequence_out <= seq_d;
      ready_out    <= ready_d;
      busy_out     <= busy_d;
      done_out     <= done_d;
    end
  end

  // Fed the next line level so the count lands together with sequence_out.
  snail_rise_counter u_rise_counter (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clear  (capture),
    .enable (state_q != ST_IDLE),
    .line   (seq_d),
    .count  (smile_cnt_out)
  );

endmodule

// File: tb/tb_snail_seq_tx.sv
// Scoreboard bench for snail_seq_tx: the driver pushes the expected frame at each
// capture; a negedge monitor collects the line and compares at every done_out.
module tb_snail_seq_tx;

  localparam int DATA_W = 8;
`ifdef SNAIL_TX_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b0;
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              ready_out, sequence_out, busy_out, done_out;
  logic [7:0]        smile_cnt_out;

  snail_seq_tx #(.DATA_W(DATA_W)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .data_in       (data_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .sequence_out  (sequence_out),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .smile_cnt_out (smile_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic [32:0] bits;
    int          n;
    int          smile;
    int          done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the frame as a list of line levels, then rises counted over
  // that list followed by the idle-high done cycle, starting from idle high.
  function automatic exp_t model(input logic [DATA_W-1:0] d);
    exp_t e;
    int   prev;
    e.bits = '0;
    e.n    = 0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      e.bits[e.n] = d[i];
      e.n++;
    end
`ifdef SNAIL_TX_PARITY_EN
    e.bits[e.n] = ^d;
    e.n++;
`endif
    prev    = 1;
    e.smile = 0;
    for (int i = 0; i < e.n; i++) begin
      if (e.bits[i] == 1'b1 && prev == 0) e.smile++;
      prev = int'(e.bits[i]);
    end
    if (prev == 0) e.smile++;
    e.done_cyc = 0;
    return e;
  endfunction

  // Holds valid_in high until the DUT takes a payload; with rnd set the offered
  // payload changes every cycle, so anything offered while busy must be dropped.
  task automatic offer(input logic [DATA_W-1:0] d, input bit rnd);
    bit   taken = 1'b0;
    int   budget = 0;
    exp_t e;
    valid_in = 1'b1;
    while (!taken) begin
      data_in = rnd ? DATA_W'($urandom) : d;
      if (ready_out) begin
        taken      = 1'b1;
        e          = model(data_in);
        e.done_cyc = cyc + 1 + FRAME_LEN;
        exp_q.push_back(e);
      end
      @(negedge clk_in);
      budget++;
      if (!taken && budget > 200) begin
        check("offer_timeout_ready", 64'(ready_out), 64'(1));
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) @(negedge clk_in);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seq"},   64'(sequence_out),  64'(1));
    check({tag, "_ready"}, 64'(ready_out),     64'(1));
    check({tag, "_busy"},  64'(busy_out),      64'(0));
    check({tag, "_done"},  64'(done_out),      64'(0));
    check({tag, "_smile"}, 64'(smile_cnt_out), 64'(0));
  endtask

  // Monitor: collects the line while busy, checks idle level between frames,
  // and scores each done_out against the front of the expectation queue.
  initial begin : monitor
    logic [32:0] col;
    int          col_n;
    int          last_smile;
    exp_t        e;
    col        = '0;
    col_n      = 0;
    last_smile = 0;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        col        = '0;
        col_n      = 0;
        last_smile = 0;
      end else begin
        if (busy_out) begin
          check("ready_low_in_frame", 64'(ready_out), 64'(0));
          if (col_n < 33) col[col_n] = sequence_out;
          col_n++;
        end else begin
          check("idle_line_high", 64'(sequence_out), 64'(1));
          check("idle_ready_high", 64'(ready_out), 64'(1));
          if (!done_out) check("smile_held", 64'(smile_cnt_out), 64'(last_smile));
        end
        if (done_out) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 64'(done_out), 64'(0));
          end else begin
            e = exp_q.pop_front();
            check("frame_len", 64'(col_n), 64'(e.n));
            check("frame_bits", 64'(col), 64'(e.bits));
            check("smile_cnt", 64'(smile_cnt_out), 64'(e.smile));
            check("done_cycle", 64'(cyc), 64'(e.done_cyc));
            check("smile_bound", 64'(int'(smile_cnt_out) <= DATA_W / 2 + 1), 64'(1));
            last_smile = e.smile;
          end
          col   = '0;
          col_n = 0;
        end
      end
    end
  end

  initial begin : driver
    int budget;
    valid_in = 1'b0;
    data_in  = '0;
    rst_in   = 1'b1;
    #1;
    check_reset_outputs("por");
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;

    // Directed frames: alternating pattern, all zeros, all ones.
    offer(8'hA5, 1'b0);
    idle(FRAME_LEN + 4);
    offer(8'h00, 1'b0);
    idle(FRAME_LEN + 4);
    offer(8'hFF, 1'b0);
    idle(FRAME_LEN + 4);

    // Back-to-back with valid held, then a stray valid during the second frame.
    offer(8'hA5, 1'b0);
    offer(8'h3C, 1'b0);
    valid_in = 1'b0;
    repeat (2) @(negedge clk_in);
    data_in  = 8'h99;
    valid_in = 1'b1;
    check("stray_valid_ready", 64'(ready_out), 64'(0));
    @(negedge clk_in);
    idle(FRAME_LEN + 4);

    // Reset on the fourth bit of a frame aborts it; a new frame follows at once.
    offer(8'hC3, 1'b0);
    valid_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    exp_q.delete();
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    offer(8'h5A, 1'b0);
    check("post_rst_capture_busy", 64'(busy_out), 64'(1));
    idle(FRAME_LEN + 4);

    // Randomized payloads, gaps and back-to-back runs.
    for (int i = 0; i < 60; i++) begin
      offer('0, 1'b1);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 5));
    end

    valid_in = 1'b0;
    budget   = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(negedge clk_in);
      budget++;
    end
    @(negedge clk_in);
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
